// File: rtl/bgp_ctrl_pkg.sv
// Shared state encodings, default timing constants and output bundle for the bandgap startup controller.
package bgp_ctrl_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SETTLE    = 3'd1;
    localparam logic [2:0] ST_CHECK     = 3'd2;
    localparam logic [2:0] ST_READY     = 3'd3;
    localparam logic [2:0] ST_RETRY_OFF = 3'd4;
    localparam logic [2:0] ST_FAULT     = 3'd5;

    localparam int DEF_SETTLE_CYCLES   = 64;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_CHECK_TIMEOUT   = 32;
    localparam int DEF_OFF_CYCLES      = 8;
    localparam int DEF_MAX_RETRIES     = 2;

    typedef struct packed {
        logic en;
        logic ready;
        logic fault;
    } bgp_out_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bgp_sync2.sv
// Two-flop synchronizer for the asynchronous comparator flag; 2-cycle latency, no backpressure.
module bgp_sync2 (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/bgp_startup_ctrl.sv
// Bandgap enable/settle/check sequencer with debounced good-reference detection, retries and sticky fault.
// Outputs registered one cycle after the deciding sample; no backpressure, start/stop sampled every cycle.
module bgp_startup_ctrl
    import bgp_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CHECK_TIMEOUT   = DEF_CHECK_TIMEOUT,
    parameter int OFF_CYCLES      = DEF_OFF_CYCLES,
    parameter int MAX_RETRIES     = DEF_MAX_RETRIES
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       start,
    input  logic       stop,
    input  logic       vbgp_ok,
    output logic       en,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state,
    output logic [1:0] retry_cnt
);

    // One phase counter is shared by SETTLE, CHECK timeout and RETRY_OFF since they never overlap.
    localparam int PHASE_MAX = max3(SETTLE_CYCLES, CHECK_TIMEOUT, OFF_CYCLES);
    localparam int CW        = $clog2(PHASE_MAX + 1);
    localparam int DW        = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(CHECK_TIMEOUT - 1);
    localparam logic [CW-1:0] OFF_LAST     = CW'(OFF_CYCLES - 1);
    localparam logic [DW-1:0] DEB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]    RETRY_MAX    = 2'(MAX_RETRIES);

    logic          ok_s;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] dbc_q, dbc_d;
    logic [1:0]    retry_q, retry_d;
    bgp_out_t      out_q, out_d;
    logic          attempt_fail;

    bgp_sync2 u_sync (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .d        (vbgp_ok),
        .q        (ok_s)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dbc_d        = dbc_q;
        retry_d      = retry_q;
        attempt_fail = 1'b0;

        if (stop) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            dbc_d   = '0;
            retry_d = 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_SETTLE;
                        cnt_d   = '0;
                        dbc_d   = '0;
                        retry_d = 2'd0;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_CHECK;
                        cnt_d   = '0;
                        dbc_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_CHECK: begin
                    // Confirmation is evaluated first so it wins a tie with the timeout.
                    if (ok_s && (dbc_q == DEB_LAST)) begin
                        state_d = ST_READY;
                        cnt_d   = '0;
                        dbc_d   = '0;
                    end else begin
                        dbc_d = ok_s ? (dbc_q + 1'b1) : '0;
                        if (cnt_q == TIMEOUT_LAST) begin
                            attempt_fail = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_READY: begin
                    if (ok_s) begin
                        dbc_d = '0;
                    end else if (dbc_q == DEB_LAST) begin
                        attempt_fail = 1'b1;
                    end else begin
                        dbc_d = dbc_q + 1'b1;
                    end
                end
                ST_RETRY_OFF: begin
                    if (cnt_q == OFF_LAST) begin
                        state_d = ST_SETTLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    dbc_d   = '0;
                    retry_d = 2'd0;
                end
            endcase

            // Guarding the increment keeps retry_cnt saturated at the limit.
            if (attempt_fail) begin
                cnt_d = '0;
                dbc_d = '0;
                if (retry_q < RETRY_MAX) begin
                    state_d = ST_RETRY_OFF;
                    retry_d = retry_q + 2'd1;
                end else begin
                    state_d = ST_FAULT;
                end
            end
        end

        out_d.en    = (state_d == ST_SETTLE) || (state_d == ST_CHECK) || (state_d == ST_READY);
        out_d.ready = (state_d == ST_READY);
        out_d.fault = (state_d == ST_FAULT);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dbc_q   <= '0;
            retry_q <= 2'd0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dbc_q   <= dbc_d;
            retry_q <= retry_d;
            out_q   <= out_d;
        end
    end

    assign en        = out_q.en;
    assign ready     = out_q.ready;
    assign fault     = out_q.fault;
    assign state     = state_q;
    assign retry_cnt = retry_q;

endmodule
